// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button/tick inputs, timer control and display outputs of stopwatch_ctrl.
interface stopwatch_ctrl_if;
  logic       btn_start_stop;
  logic       btn_lap;
  logic       btn_clear;
  logic       second_tick;
  logic       timer_en;
  logic       timer_clr;
  logic [3:0] disp_min_tens;
  logic [3:0] disp_min_ones;
  logic [3:0] disp_sec_tens;
  logic [3:0] disp_sec_ones;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output btn_start_stop, btn_lap, btn_clear, second_tick,
    input  timer_en, timer_clr, disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones,
    input  running, lap_active, overflow
  );

  modport slave (
    input  btn_start_stop, btn_lap, btn_clear, second_tick,
    output timer_en, timer_clr, disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones,
    output running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - mm:ss BCD stopwatch control FSM sequencing the one-second timer.
// Lap capture and LAP_HOLD are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int MAX_MIN_TENS = 9
) (
  input logic             clk,
  input logic             n_rst,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    PAUSE    = 2'd2
`ifdef STOPWATCH_LAP_EN
    ,LAP_HOLD = 2'd3
`endif
  } state_t;

  localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

  state_t      state;
  logic        prev_ss;
  logic        prev_clr;
  logic        ss_press;
  logic        clr_press;
  logic        counting;
  logic        clr_pulse;
  logic        ovf;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
  logic [3:0]  nxt_sec_ones, nxt_sec_tens, nxt_min_ones, nxt_min_tens;
  logic        wrap;
  logic [15:0] live_count;
  logic [15:0] disp;

  assign ss_press   = sw.btn_start_stop & ~prev_ss;
  assign clr_press  = sw.btn_clear & ~prev_clr;
  assign live_count = {min_tens, min_ones, sec_tens, sec_ones};

`ifdef STOPWATCH_LAP_EN
  logic        prev_lap;
  logic        lap_press;
  logic [15:0] lap_count;

  assign lap_press     = sw.btn_lap & ~prev_lap;
  assign counting      = (state == RUN) || (state == LAP_HOLD);
  assign sw.lap_active = (state == LAP_HOLD);
  assign disp          = (state == LAP_HOLD) ? lap_count : live_count;
`else
  logic unused_lap;

  assign unused_lap    = sw.btn_lap;
  assign counting      = (state == RUN);
  assign sw.lap_active = 1'b0;
  assign disp          = live_count;
`endif

  assign sw.running       = counting;
  assign sw.timer_en      = counting;
  assign sw.timer_clr     = clr_pulse;
  assign sw.overflow      = ovf;
  assign sw.disp_min_tens = disp[15:12];
  assign sw.disp_min_ones = disp[11:8];
  assign sw.disp_sec_tens = disp[7:4];
  assign sw.disp_sec_ones = disp[3:0];

  // Ripple-carry BCD increment; wrap only when every digit is at its ceiling.
  always_comb begin
    nxt_sec_ones = sec_ones + 4'd1;
    nxt_sec_tens = sec_tens;
    nxt_min_ones = min_ones;
    nxt_min_tens = min_tens;
    wrap         = 1'b0;
    if (sec_ones == 4'd9) begin
      nxt_sec_ones = 4'd0;
      nxt_sec_tens = sec_tens + 4'd1;
      if (sec_tens == 4'd5) begin
        nxt_sec_tens = 4'd0;
        nxt_min_ones = min_ones + 4'd1;
        if (min_ones == 4'd9) begin
          nxt_min_ones = 4'd0;
          nxt_min_tens = min_tens + 4'd1;
          if (min_tens == MT_MAX) begin
            nxt_min_tens = 4'd0;
            wrap         = 1'b1;
          end
        end
      end
    end
  end

  // Prev-registers reset high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state     <= IDLE;
      prev_ss   <= 1'b1;
      prev_clr  <= 1'b1;
      sec_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      min_ones  <= 4'd0;
      min_tens  <= 4'd0;
      ovf       <= 1'b0;
      clr_pulse <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      prev_lap  <= 1'b1;
      lap_count <= 16'd0;
`endif
    end else begin
      prev_ss   <= sw.btn_start_stop;
      prev_clr  <= sw.btn_clear;
      clr_pulse <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      prev_lap  <= sw.btn_lap;
`endif
      if (counting && sw.second_tick) begin
        sec_ones <= nxt_sec_ones;
        sec_tens <= nxt_sec_tens;
        min_ones <= nxt_min_ones;
        min_tens <= nxt_min_tens;
        if (wrap) ovf <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ss_press) state <= RUN;
        end
        RUN: begin
          if (ss_press) state <= PAUSE;
`ifdef STOPWATCH_LAP_EN
          else if (lap_press) begin
            state     <= LAP_HOLD;
            lap_count <= live_count;
          end
`endif
        end
`ifdef STOPWATCH_LAP_EN
        LAP_HOLD: begin
          if (ss_press) state <= PAUSE;
          else if (lap_press) state <= RUN;
        end
`endif
        PAUSE: begin
          if (clr_press) begin
            state     <= IDLE;
            sec_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            min_ones  <= 4'd0;
            min_tens  <= 4'd0;
            ovf       <= 1'b0;
            clr_pulse <= 1'b1;
          end else if (ss_press) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - table-driven bench for stopwatch_ctrl built with MAX_MIN_TENS=0.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.MAX_MIN_TENS(0)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .sw   (sw)
  );

  typedef struct {
    int          reps;
    logic        ss;
    logic        lap;
    logic        clr;
    logic        tick;
    logic        en;
    logic        tclr;
    logic        lapact;
    logic        ovf;
    logic [15:0] disp;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(int reps, logic ss, logic lap, logic clr, logic tick,
                              logic en, logic tclr, logic lapact, logic ovf, logic [15:0] disp);
    vec_t v;
    v.reps = reps; v.ss = ss; v.lap = lap; v.clr = clr; v.tick = tick;
    v.en = en; v.tclr = tclr; v.lapact = lapact; v.ovf = ovf; v.disp = disp;
    return v;
  endfunction

  // {timer_en, running, timer_clr, lap_active, overflow, mm:ss}
  function automatic logic [20:0] observed();
    return {sw.timer_en, sw.running, sw.timer_clr, sw.lap_active, sw.overflow,
            sw.disp_min_tens, sw.disp_min_ones, sw.disp_sec_tens, sw.disp_sec_ones};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic drive(input logic ss, input logic lap, input logic clr, input logic tick);
    sw.btn_start_stop = ss;
    sw.btn_lap        = lap;
    sw.btn_clear      = clr;
    sw.second_tick    = tick;
  endtask

  initial begin
    //             reps ss lp cl tk  en tc la ov disp
    vecs.push_back(mk(1,   1, 0, 0, 0,  0, 0, 0, 0, 16'h0000)); // held through reset
    vecs.push_back(mk(1,   0, 0, 0, 0,  0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1,   0, 0, 1, 0,  0, 0, 0, 0, 16'h0000)); // clear in IDLE
    vecs.push_back(mk(1,   0, 0, 0, 0,  0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1,   1, 0, 0, 0,  1, 0, 0, 0, 16'h0000)); // start
    vecs.push_back(mk(1,   1, 0, 0, 1,  1, 0, 0, 0, 16'h0001)); // held level, tick
    vecs.push_back(mk(1,   0, 0, 1, 0,  1, 0, 0, 0, 16'h0001)); // clear in RUN ignored
    vecs.push_back(mk(1,   0, 0, 0, 1,  1, 0, 0, 0, 16'h0002));
    vecs.push_back(mk(73,  0, 0, 0, 1,  1, 0, 0, 0, 16'h0115));
    vecs.push_back(mk(1,   1, 0, 0, 0,  0, 0, 0, 0, 16'h0115)); // pause
    vecs.push_back(mk(1,   0, 0, 0, 1,  0, 0, 0, 0, 16'h0115)); // late tick
    vecs.push_back(mk(3,   0, 0, 0, 1,  0, 0, 0, 0, 16'h0115)); // ticks in PAUSE
    vecs.push_back(mk(1,   0, 0, 1, 0,  0, 1, 0, 0, 16'h0000)); // clear
    vecs.push_back(mk(1,   0, 0, 0, 0,  0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1,   1, 0, 0, 0,  1, 0, 0, 0, 16'h0000)); // start from IDLE
    vecs.push_back(mk(3,   0, 0, 0, 1,  1, 0, 0, 0, 16'h0003));
    vecs.push_back(mk(1,   1, 0, 0, 0,  0, 0, 0, 0, 16'h0003));
    vecs.push_back(mk(1,   0, 0, 0, 0,  0, 0, 0, 0, 16'h0003));
    vecs.push_back(mk(1,   1, 0, 1, 0,  0, 1, 0, 0, 16'h0000)); // start+clear: clear wins
    vecs.push_back(mk(1,   0, 0, 0, 0,  0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1,   1, 0, 0, 0,  1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(10,  0, 0, 0, 1,  1, 0, 0, 0, 16'h0010));
`ifdef STOPWATCH_LAP_EN
    vecs.push_back(mk(1,   0, 1, 0, 1,  1, 0, 1, 0, 16'h0010)); // lap with tick
    vecs.push_back(mk(5,   0, 0, 0, 1,  1, 0, 1, 0, 16'h0010));
    vecs.push_back(mk(1,   0, 1, 0, 0,  1, 0, 0, 0, 16'h0016)); // lap again -> live
`else
    vecs.push_back(mk(1,   0, 1, 0, 1,  1, 0, 0, 0, 16'h0011)); // lap ignored
    vecs.push_back(mk(5,   0, 0, 0, 1,  1, 0, 0, 0, 16'h0016));
    vecs.push_back(mk(1,   0, 1, 0, 0,  1, 0, 0, 0, 16'h0016));
`endif
    vecs.push_back(mk(1,   0, 0, 0, 0,  1, 0, 0, 0, 16'h0016));
    vecs.push_back(mk(1,   1, 0, 0, 0,  0, 0, 0, 0, 16'h0016));
    vecs.push_back(mk(1,   0, 0, 1, 0,  0, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(1,   1, 0, 0, 0,  1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1,   0, 0, 0, 0,  1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(599, 0, 0, 0, 1,  1, 0, 0, 0, 16'h0959));
    vecs.push_back(mk(1,   0, 0, 0, 1,  1, 0, 0, 1, 16'h0000)); // wrap
    vecs.push_back(mk(2,   0, 0, 0, 1,  1, 0, 0, 1, 16'h0002));
    vecs.push_back(mk(1,   1, 0, 0, 0,  0, 0, 0, 1, 16'h0002));
    vecs.push_back(mk(1,   0, 0, 0, 0,  0, 0, 0, 1, 16'h0002));
    vecs.push_back(mk(1,   1, 0, 0, 0,  1, 0, 0, 1, 16'h0002)); // overflow sticky
    vecs.push_back(mk(1,   0, 0, 0, 0,  1, 0, 0, 1, 16'h0002));
    vecs.push_back(mk(1,   1, 0, 0, 0,  0, 0, 0, 1, 16'h0002));
    vecs.push_back(mk(1,   0, 0, 1, 0,  0, 1, 0, 0, 16'h0000)); // clear drops overflow
    vecs.push_back(mk(1,   0, 0, 0, 0,  0, 0, 0, 0, 16'h0000));

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", observed(), 21'h0);
    @(negedge clk);
    n_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(vecs[i].ss, vecs[i].lap, vecs[i].clr, vecs[i].tick);
        @(posedge clk);
        #1;
      end
      check($sformatf("vec%0d", i), observed(),
            {vecs[i].en, vecs[i].en, vecs[i].tclr, vecs[i].lapact, vecs[i].ovf, vecs[i].disp});
    end

    // Asynchronous reset in the middle of a running count.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_run", observed(), {2'b11, 3'b000, 16'h0002});
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    n_rst = 1'b1;
    #1;
    check("async_reset", observed(), 21'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("held_in_reset", observed(), 21'h0);
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk); #1;
    check("held_after_reset", observed(), 21'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM that sequences the one-second `timer` block and turns its ticks into an mm:ss BCD stopwatch count. It takes three synchronous, debounced pushbutton levels (start/stop, lap, clear), detects their rising edges and drives the timer's enable and clear. It accumulates `second_tick` pulses into BCD digits and presents a live or lap-frozen display to the seven-segment driver.

## Interface
- `MAX_MIN_TENS`, default 9: upper bound of the minutes-tens digit. The count wraps after `MAX_MIN_TENS`9:59.
- `clk` input 1: system clock.
- `n_rst` input 1: reset, asynchronous, active-high.
- `btn_start_stop` input 1: debounced start/stop level.
- `btn_lap` input 1: debounced lap level.
- `btn_clear` input 1: debounced clear level.
- `second_tick` input 1: one-cycle pulse from `timer`.
- `timer_en` output 1: enable to `timer`.
- `timer_clr` output 1: one-cycle reset pulse to `timer`, active-high.
- `disp_min_tens`, `disp_min_ones`, `disp_sec_tens`, `disp_sec_ones` output 4 each: BCD display digits.
- `running` output 1: state is RUN or LAP_HOLD.
- `lap_active` output 1: state is LAP_HOLD.
- `overflow` output 1: sticky flag, set on count wrap.

## Operation
- **Edge detect**
  - One prev-register per button.
  - A press is `btn=1` while `prev=0`.
  - All prev-registers reset to 1, so a button held through reset is ignored until it is released and pressed again.
- **States:** IDLE, RUN, PAUSE, LAP_HOLD. Transitions, with priority among simultaneous presses clear > start_stop > lap:
  - IDLE: start_stop → RUN. Lap and clear are ignored.
  - RUN: start_stop → PAUSE; lap → LAP_HOLD, capturing the live count into the lap register. Clear is ignored.
  - LAP_HOLD: start_stop → PAUSE, display returns to live; lap → RUN, display returns to live. Clear is ignored.
  - PAUSE: start_stop → RUN; clear → IDLE, zeroing the count and `overflow` and pulsing `timer_clr`. Lap is ignored.
- **Outputs**
  - `timer_en` = `running`, decoded from the state register.
- **Counting**
  - The count is only updated on a `second_tick` seen in RUN or LAP_HOLD. Ticks in IDLE or PAUSE are dropped, including a late tick arriving the cycle after a stop.
  - `sec_ones` counts 0–9, `sec_tens` 0–5, `min_ones` 0–9, `min_tens` 0–`MAX_MIN_TENS`, each carrying into the next.
  - At `MAX_MIN_TENS`9:59, a tick wraps the count to 00:00 and sets `overflow`. Counting continues.
- **Display**
  - LAP_HOLD shows the lap register; every other state shows the live count.
- **Lap capture**
  - The capture takes the pre-increment value when a tick coincides with the lap press.
  - The live count still increments on that edge.

## Timing
- **Reset values:**
  - State IDLE.
  - All digits and the lap register 0.
  - `timer_en`, `timer_clr`, `running`, `lap_active` and `overflow` all 0.
- **Press latency:**
  - A press sampled at edge N changes the state at edge N.
  - `timer_en` and `running` reflect the new state in cycle N+1.
- **Clear latency:**
  - `timer_clr` is registered: high for exactly cycle N+1 after a clear accepted at edge N.
  - Digits read 0 in cycle N+1.
- **Tick latency:**
  - A tick at edge N updates the digits visible in cycle N+1.
- **Repeated presses:**
  - A level held high produces one press only.
  - Back-to-back presses need the button low for at least one cycle between them.
- **Reset mid-operation:**
  - Asserting `n_rst` forces all reset values immediately (asynchronous), whatever the state.
  - `timer_clr` stays 0 during reset; the timer shares `n_rst`.

## Configuration
- `STOPWATCH_LAP_EN`
  - **Defined:** the lap feature is present as described above.
  - **Undefined:**
    - The lap register, lap edge detector and LAP_HOLD state are not built.
    - `btn_lap` is ignored and `lap_active` is tied 0.
    - The display is always live.
    - All other behaviour is unchanged.

## Test plan
- **Held button over reset:** hold `btn_start_stop=1` through reset release → no transition and `timer_en=0`. Release, then press → `timer_en=1` one cycle after the press edge.
- **Run and pause:** start, apply 75 ticks, pause → display 01:15. A tick injected in PAUSE and a late tick in the cycle after the stop both leave 01:15.
- **Clear:** in PAUSE at 01:15, press clear → `timer_clr` high for 1 cycle, display 00:00, state IDLE. A clear press in RUN is ignored.
- **Lap:** at 00:10, press lap together with a tick → display holds 00:10 while 5 more ticks arrive. Lap again → display shows 00:16.
- **Wrap:** with `MAX_MIN_TENS=0`, run to 09:59, apply one tick → display 00:00 and `overflow=1`. `overflow` stays 1 until a clear in PAUSE.
- **Simultaneous presses:** in PAUSE, press start_stop and clear in the same cycle → IDLE with count 0 (clear wins).
